sram_like_arbiter: RTL and testbench

- Parametrised successor to the fixed single-cycle inst/data SRAM ports of the core top level.
- Arbitrates NUM_CH independent master channels onto one class-SRAM (req/addr_ok/data_ok) bus.
- Supports up to MAX_OUT in-flight transactions, with responses returned in order.
- Sits between the fetch/mem stages (channel 0 = IF, 1 = MEM, others spare) and the external memory bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/sram_like_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the class-SRAM channel arbiter:
//   - transfer size encodings as driven on ch_size / bus_size
//   - well-known channel ids (instruction fetch, memory stage)
//   - CLOG2 helper used to size id, pointer and count fields
// No ports; imported by sram_like_arbiter and sync_fifo.
// -----------------------------------------------------------------------------
package sram_like_arbiter_pkg;

  // Transfer size encodings
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Channel ids of the core pipeline masters
  localparam int CH_IF  = 0;
  localparam int CH_MEM = 1;

  // Ceiling log2; CLOG2(1) = 0, CLOG2(2) = 1, CLOG2(5) = 3
  function automatic int CLOG2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in first-out queue with occupancy count. Depth need not
// be a power of two: pointers wrap with an explicit compare against DEPTH-1.
// Push while full and pop while empty are ignored so that a misbehaving
// producer or consumer can never corrupt pointers or count.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (pointers and count only)
//   push   in   write wdata at the tail
//   pop    in   drop the head entry
//   wdata  in   WIDTH  data to enqueue
//   rdata  out  WIDTH  head entry (valid when !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  CNT_W  number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int CNT_W = CLOG2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? CLOG2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only and is never reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
// Arbitrates NUM_CH class-SRAM master channels onto one class-SRAM bus with up
// to MAX_OUT accepted-but-unanswered transactions. Responses come back in
// acceptance order; an id queue records which channel owns each outstanding
// transaction so bus_data_ok can be steered to it.
//
// Grant is combinational over ch_req while unlocked (fixed priority, lowest
// index wins, or round-robin from rr_ptr). Once the bus sees a request that it
// does not accept, the grant is locked so the bus fields stay stable until
// bus_addr_ok, regardless of later higher-priority arrivals.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   ch_req       in   NUM_CH     per-channel request
//   ch_wr        in   NUM_CH     1 = write
//   ch_size      in   2*NUM_CH   size, channel i at [2i+1:2i]
//   ch_addr      in   32*NUM_CH  byte address
//   ch_wstrb     in   4*NUM_CH   byte enables
//   ch_wdata     in   32*NUM_CH  write data
//   ch_addr_ok   out  NUM_CH     request of channel i accepted this cycle
//   ch_data_ok   out  NUM_CH     response for channel i this cycle
//   ch_rdata     out  32         shared read data, valid with ch_data_ok
//   bus_req      out  1          bus request
//   bus_wr/size/addr/wstrb/wdata out  fields of the granted channel
//   bus_addr_ok  in   1          bus accepted the request
//   bus_data_ok  in   1          bus response
//   bus_rdata    in   32         bus read data
//   err_unexp    out  1          sticky: response with nothing outstanding
// -----------------------------------------------------------------------------
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int MAX_OUT = 4,
  parameter int ARB_RR  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_wr,
  input  logic [2*NUM_CH-1:0]  ch_size,
  input  logic [32*NUM_CH-1:0] ch_addr,
  input  logic [4*NUM_CH-1:0]  ch_wstrb,
  input  logic [32*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]    ch_addr_ok,
  output logic [NUM_CH-1:0]    ch_data_ok,
  output logic [31:0]          ch_rdata,
  output logic                 bus_req,
  output logic                 bus_wr,
  output logic [1:0]           bus_size,
  output logic [31:0]          bus_addr,
  output logic [3:0]           bus_wstrb,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_addr_ok,
  input  logic                 bus_data_ok,
  input  logic [31:0]          bus_rdata,
  output logic                 err_unexp
);

  localparam int ID_W  = (NUM_CH > 1) ? CLOG2(NUM_CH) : 1;
  localparam int CNT_W = CLOG2(MAX_OUT + 1);

  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  search_id;
  logic [ID_W-1:0]  lock_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  head_id;
  logic             locked;
  logic             any_req;
  logic             accept;
  logic             rsp_valid;
  logic             rsp_unexp;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Lowest requesting index
  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_CH-1:0] req);
    logic [ID_W-1:0] id;
    id = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        id = ID_W'(k);
      end
    end
    return id;
  endfunction

  // First requesting index at or after ptr, wrapping modulo NUM_CH.
  // Scanning from the far end lets the nearest hit overwrite the others.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_CH-1:0] req,
                                              input logic [ID_W-1:0]   ptr);
    logic [ID_W-1:0] id;
    int              idx;
    id = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (req[idx]) begin
        id = ID_W'(idx);
      end
    end
    return id;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_CH - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  // Grant selection and bus request
  assign any_req   = |ch_req;
  assign search_id = (ARB_RR != 0) ? pick_rr(ch_req, rr_ptr) : pick_fixed(ch_req);
  assign grant     = locked ? lock_id : search_id;

  // A full id queue masks the request but leaves any lock in place, so the
  // same channel is presented again once a response frees a slot.
  assign bus_req   = ~reset & (locked | any_req) & ~fifo_full;
  assign accept    = bus_req & bus_addr_ok;

  assign bus_wr    = ch_wr[grant];
  assign bus_size  = ch_size[int'(grant)*2 +: 2];
  assign bus_addr  = ch_addr[int'(grant)*32 +: 32];
  assign bus_wstrb = ch_wstrb[int'(grant)*4 +: 4];
  assign bus_wdata = ch_wdata[int'(grant)*32 +: 32];

  always_comb begin
    ch_addr_ok = '0;
    if (accept) begin
      ch_addr_ok[grant] = 1'b1;
    end
  end

  // Response steering: the queue head owns the oldest outstanding request.
  // Responses arriving during reset are dropped along with the queue.
  assign rsp_valid = ~reset & bus_data_ok & ~fifo_empty;
  assign rsp_unexp = ~reset & bus_data_ok & fifo_empty;
  assign ch_rdata  = bus_rdata;

  always_comb begin
    ch_data_ok = '0;
    if (rsp_valid) begin
      ch_data_ok[head_id] = 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp_valid),
    .wdata (grant),
    .rdata (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control state: lock, round-robin pointer, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      locked    <= 1'b0;
      rr_ptr    <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (accept) begin
        locked <= 1'b0;
        rr_ptr <= next_id(grant);
      end else if (bus_req) begin
        locked <= 1'b1;
      end
      if (rsp_unexp) begin
        err_unexp <= 1'b1;
      end
    end
  end

  // Locked channel id; while locked, grant already equals lock_id
  always_ff @(posedge clk) begin
    if (bus_req && !bus_addr_ok) begin
      lock_id <= grant;
    end
  end

  occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
// Scoreboard bench: stimulus pushes expected grants and responses into queues,
// a negedge monitor pops and compares whenever a DUT presents ch_addr_ok or
// ch_data_ok. Two instances: fixed priority (2 ch, depth 4) and round-robin
// (3 ch, depth 6).
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic reset;

  // Fixed-priority instance
  logic [1:0]  f_req, f_wr, f_addr_ok_o, f_data_ok_o;
  logic [3:0]  f_size;
  logic [63:0] f_addr, f_wdata;
  logic [7:0]  f_wstrb;
  logic [31:0] f_rdata_o, f_bus_addr, f_bus_wdata, f_bus_rdata;
  logic        f_bus_req, f_bus_wr, f_bus_addr_ok, f_bus_data_ok, f_err;
  logic [1:0]  f_bus_size;
  logic [3:0]  f_bus_wstrb;

  // Round-robin instance
  logic [2:0]  r_req, r_wr, r_addr_ok_o, r_data_ok_o;
  logic [5:0]  r_size;
  logic [95:0] r_addr, r_wdata;
  logic [11:0] r_wstrb;
  logic [31:0] r_rdata_o, r_bus_addr, r_bus_wdata, r_bus_rdata;
  logic        r_bus_req, r_bus_wr, r_bus_addr_ok, r_bus_data_ok, r_err;
  logic [1:0]  r_bus_size;
  logic [3:0]  r_bus_wstrb;

  int   total;
  int   bad;
  int   exp_f_addr[$];
  int   exp_r_addr[$];
  rsp_t exp_f_rsp[$];
  rsp_t exp_r_rsp[$];
  int   mf_a, mr_a;
  rsp_t mf_r, mr_r;

  sram_like_arbiter #(.NUM_CH(2), .MAX_OUT(4), .ARB_RR(0)) u_fp (
    .clk(clk), .reset(reset),
    .ch_req(f_req), .ch_wr(f_wr), .ch_size(f_size), .ch_addr(f_addr),
    .ch_wstrb(f_wstrb), .ch_wdata(f_wdata),
    .ch_addr_ok(f_addr_ok_o), .ch_data_ok(f_data_ok_o), .ch_rdata(f_rdata_o),
    .bus_req(f_bus_req), .bus_wr(f_bus_wr), .bus_size(f_bus_size),
    .bus_addr(f_bus_addr), .bus_wstrb(f_bus_wstrb), .bus_wdata(f_bus_wdata),
    .bus_addr_ok(f_bus_addr_ok), .bus_data_ok(f_bus_data_ok),
    .bus_rdata(f_bus_rdata), .err_unexp(f_err)
  );

  sram_like_arbiter #(.NUM_CH(3), .MAX_OUT(6), .ARB_RR(1)) u_rr (
    .clk(clk), .reset(reset),
    .ch_req(r_req), .ch_wr(r_wr), .ch_size(r_size), .ch_addr(r_addr),
    .ch_wstrb(r_wstrb), .ch_wdata(r_wdata),
    .ch_addr_ok(r_addr_ok_o), .ch_data_ok(r_data_ok_o), .ch_rdata(r_rdata_o),
    .bus_req(r_bus_req), .bus_wr(r_bus_wr), .bus_size(r_bus_size),
    .bus_addr(r_bus_addr), .bus_wstrb(r_bus_wstrb), .bus_wdata(r_bus_wdata),
    .bus_addr_ok(r_bus_addr_ok), .bus_data_ok(r_bus_data_ok),
    .bus_rdata(r_bus_rdata), .err_unexp(r_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_f(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    f_wr[i]            = wr;
    f_size[2*i +: 2]   = SZ_W;
    f_addr[32*i +: 32] = addr;
    f_wstrb[4*i +: 4]  = 4'hf;
    f_wdata[32*i +: 32] = wdata;
  endtask

  // Monitor: compare every presented grant / response against the scoreboard
  always @(negedge clk) begin
    if (f_addr_ok_o != '0) begin
      if (exp_f_addr.size() == 0) begin
        check("fp_addr_ok_unexpected", 64'(f_addr_ok_o), 64'd0);
      end else begin
        mf_a = exp_f_addr.pop_front();
        check("fp_addr_ok", 64'(f_addr_ok_o), 64'd1 << mf_a);
      end
    end
    if (f_data_ok_o != '0) begin
      if (exp_f_rsp.size() == 0) begin
        check("fp_data_ok_unexpected", 64'(f_data_ok_o), 64'd0);
      end else begin
        mf_r = exp_f_rsp.pop_front();
        check("fp_data_ok", 64'(f_data_ok_o), 64'd1 << mf_r.ch);
        check("fp_rdata", 64'(f_rdata_o), 64'(mf_r.data));
      end
    end
    if (r_addr_ok_o != '0) begin
      if (exp_r_addr.size() == 0) begin
        check("rr_addr_ok_unexpected", 64'(r_addr_ok_o), 64'd0);
      end else begin
        mr_a = exp_r_addr.pop_front();
        check("rr_addr_ok", 64'(r_addr_ok_o), 64'd1 << mr_a);
      end
    end
    if (r_data_ok_o != '0) begin
      if (exp_r_rsp.size() == 0) begin
        check("rr_data_ok_unexpected", 64'(r_data_ok_o), 64'd0);
      end else begin
        mr_r = exp_r_rsp.pop_front();
        check("rr_data_ok", 64'(r_data_ok_o), 64'd1 << mr_r.ch);
        check("rr_rdata", 64'(r_rdata_o), 64'(mr_r.data));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    f_req = '0; f_wr = '0; f_size = '0; f_addr = '0; f_wstrb = '0; f_wdata = '0;
    f_bus_addr_ok = 1'b0; f_bus_data_ok = 1'b0; f_bus_rdata = '0;
    r_req = '0; r_wr = '0; r_size = '0; r_addr = '0; r_wstrb = '0; r_wdata = '0;
    r_bus_addr_ok = 1'b0; r_bus_data_ok = 1'b0; r_bus_rdata = '0;

    // Reset values
    f_req = 2'b01;
    nxt(); mid();
    check("rst_bus_req", 64'(f_bus_req), 64'd0);
    check("rst_addr_ok", 64'(f_addr_ok_o), 64'd0);
    check("rst_data_ok", 64'(f_data_ok_o), 64'd0);
    check("rst_err", 64'(f_err), 64'd0);
    check("rst_rr_bus_req", 64'(r_bus_req), 64'd0);
    nxt(); reset = 1'b0; f_req = '0;

    // Single read, fixed priority
    set_f(CH_IF, 1'b0, 32'h1c00_0000, 32'h0);
    nxt(); f_req = 2'b01; f_bus_addr_ok = 1'b1; exp_f_addr.push_back(CH_IF);
    mid();
    check("t1_bus_req", 64'(f_bus_req), 64'd1);
    check("t1_bus_addr", 64'(f_bus_addr), 64'h1c00_0000);
    nxt(); f_req = '0; f_bus_addr_ok = 1'b0;
    nxt(); f_bus_data_ok = 1'b1; f_bus_rdata = 32'h0280_0c0c;
    exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'h0280_0c0c});
    nxt(); f_bus_data_ok = 1'b0;

    // Lock: ch1 write held while ch0 arrives
    set_f(CH_MEM, 1'b1, 32'h0000_0008, 32'hdead_beef);
    set_f(CH_IF, 1'b0, 32'h0000_0100, 32'h0);
    nxt(); f_req = 2'b10; mid();
    check("t2_addr_c0", 64'(f_bus_addr), 64'h8);
    check("t2_wr_c0", 64'(f_bus_wr), 64'd1);
    nxt(); f_req = 2'b11; mid();
    check("t2_addr_c1", 64'(f_bus_addr), 64'h8);
    check("t2_wr_c1", 64'(f_bus_wr), 64'd1);
    check("t2_wdata_c1", 64'(f_bus_wdata), 64'hdead_beef);
    nxt(); mid();
    check("t2_addr_c2", 64'(f_bus_addr), 64'h8);
    nxt(); f_bus_addr_ok = 1'b1; exp_f_addr.push_back(CH_MEM); mid();
    check("t2_addr_acc", 64'(f_bus_addr), 64'h8);
    nxt(); f_req = 2'b01; exp_f_addr.push_back(CH_IF); mid();
    check("t2_addr_ch0", 64'(f_bus_addr), 64'h100);
    check("t2_wr_ch0", 64'(f_bus_wr), 64'd0);
    nxt(); f_req = '0; f_bus_addr_ok = 1'b0;
    f_bus_data_ok = 1'b1; f_bus_rdata = 32'ha;
    exp_f_rsp.push_back('{ch: 4'(CH_MEM), data: 32'ha});
    nxt(); f_bus_rdata = 32'hb;
    exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'hb});
    nxt(); f_bus_data_ok = 1'b0;

    // Full: ch1 then three ch0 accepts fill depth 4
    nxt(); f_req = 2'b10; f_bus_addr_ok = 1'b1; exp_f_addr.push_back(CH_MEM);
    for (int k = 0; k < 3; k++) begin
      nxt(); f_req = 2'b01; exp_f_addr.push_back(CH_IF);
    end
    nxt(); mid();
    check("t3_full_mask", 64'(f_bus_req), 64'd0);
    nxt(); f_bus_data_ok = 1'b1; f_bus_rdata = 32'h11;
    exp_f_rsp.push_back('{ch: 4'(CH_MEM), data: 32'h11}); mid();
    check("t3_full_pop_cycle", 64'(f_bus_req), 64'd0);
    nxt(); f_bus_data_ok = 1'b0; exp_f_addr.push_back(CH_IF); mid();
    check("t3_reassert", 64'(f_bus_req), 64'd1);
    nxt(); f_req = '0; f_bus_addr_ok = 1'b0;
    f_bus_data_ok = 1'b1; f_bus_rdata = 32'h12;
    exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'h12});
    for (int k = 1; k < 4; k++) begin
      nxt(); f_bus_rdata = 32'h12 + 32'(k);
      exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'h12 + 32'(k)});
    end
    nxt(); f_bus_data_ok = 1'b0;

    // Ordering: ch0, ch1, ch0 then three responses
    nxt(); f_req = 2'b01; f_bus_addr_ok = 1'b1; exp_f_addr.push_back(CH_IF);
    nxt(); f_req = 2'b10; exp_f_addr.push_back(CH_MEM);
    nxt(); f_req = 2'b01; exp_f_addr.push_back(CH_IF);
    nxt(); f_req = '0; f_bus_addr_ok = 1'b0;
    nxt(); f_bus_data_ok = 1'b1; f_bus_rdata = 32'd1;
    exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'd1});
    nxt(); f_bus_rdata = 32'd2;
    exp_f_rsp.push_back('{ch: 4'(CH_MEM), data: 32'd2});
    nxt(); f_bus_rdata = 32'd3;
    exp_f_rsp.push_back('{ch: 4'(CH_IF), data: 32'd3});
    nxt(); f_bus_data_ok = 1'b0;

    // Reset with two outstanding, then a stray response
    nxt(); f_req = 2'b01; f_bus_addr_ok = 1'b1; exp_f_addr.push_back(CH_IF);
    nxt(); exp_f_addr.push_back(CH_IF);
    nxt(); f_req = '0; f_bus_addr_ok = 1'b0; reset = 1'b1;
    f_bus_data_ok = 1'b1; f_bus_rdata = 32'h55; mid();
    check("t5_err_in_reset", 64'(f_err), 64'd0);
    check("t5_req_in_reset", 64'(f_bus_req), 64'd0);
    nxt(); reset = 1'b0; mid();
    check("t5_no_data_ok", 64'(f_data_ok_o), 64'd0);
    nxt(); f_bus_data_ok = 1'b0; mid();
    check("t5_err_set", 64'(f_err), 64'd1);
    nxt(); mid();
    check("t5_err_sticky", 64'(f_err), 64'd1);
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; mid();
    check("t5_err_cleared", 64'(f_err), 64'd0);

    // Round-robin over three channels, depth 6
    for (int i = 0; i < 3; i++) begin
      r_addr[32*i +: 32] = 32'h1000 * 32'(i + 1);
      r_size[2*i +: 2]   = SZ_W;
    end
    for (int k = 0; k < 6; k++) begin
      nxt(); r_req = 3'b111; r_bus_addr_ok = 1'b1; exp_r_addr.push_back(k % 3);
      mid();
      check("rr_bus_addr", 64'(r_bus_addr), 64'h1000 * 64'((k % 3) + 1));
    end
    nxt(); mid();
    check("rr_full_mask", 64'(r_bus_req), 64'd0);
    nxt(); r_req = '0; r_bus_addr_ok = 1'b0; r_bus_data_ok = 1'b1;
    r_bus_rdata = 32'h20;
    exp_r_rsp.push_back('{ch: 4'd0, data: 32'h20});
    for (int k = 1; k < 6; k++) begin
      nxt(); r_bus_rdata = 32'h20 + 32'(k);
      exp_r_rsp.push_back('{ch: 4'(k % 3), data: 32'h20 + 32'(k)});
    end
    nxt(); r_bus_data_ok = 1'b0;
    nxt(); nxt(); mid();

    check("fp_addr_left", 64'(exp_f_addr.size()), 64'd0);
    check("fp_rsp_left", 64'(exp_f_rsp.size()), 64'd0);
    check("rr_addr_left", 64'(exp_r_addr.size()), 64'd0);
    check("rr_rsp_left", 64'(exp_r_rsp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
